fetch_ctrl: RTL

Sequencing controller for the instruction-fetch stage. Each cycle it selects the next-PC source, PC write enable, exception redirect and return-from-exception redirect. It also owns the exception state that the fetch datapath consumes: interrupt address register, supervisor/user mode and interrupt enable. It sits between decode/execute hazard and exception logic and the fetch stage, and drives that stage's `pc_src`, `pc_write`, `rfe`, `exception`, `vector_no_3`, `IAR_pc` and `s_u` inputs.

---
 rtl/fetch_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Fetch-stage sequencing controller: next-PC select, exception entry,
//            rfe return and double-fault halt. Owns IAR, mode and interrupt enable.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter logic [4:0] IRQ_VEC  = 5'd2,
    parameter logic [4:0] PRIV_VEC = 5'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jump_id,
    input  logic        branch_taken,
    input  logic        jr_id,
    input  logic        rfe_id,
    input  logic [4:0]  vector_if,
    input  logic [4:0]  vector_ex,
    input  logic        irq,
    input  logic [31:0] pc_if,
    input  logic [31:0] pc_ex,
    output logic [1:0]  pc_src,
    output logic        pc_write,
    output logic        rfe,
    output logic        exception,
    output logic [4:0]  vector_no_3,
    output logic [31:0] IAR_pc,
    output logic        s_u,
    output logic        flush_if,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        halted
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        su_q, ie_q, in_handler_q, sv_su_q, sv_ie_q;
    logic [31:0] iar_q;

    logic        w_take;
    logic        w_do_rfe;
    logic [31:0] w_save_pc;

    always_comb begin
        state_d     = state_q;
        pc_src      = 2'b00;
        pc_write    = 1'b0;
        rfe         = 1'b0;
        exception   = 1'b0;
        vector_no_3 = 5'd0;
        flush_if    = 1'b0;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;
        halted      = 1'b0;
        w_take      = 1'b0;
        w_do_rfe    = 1'b0;
        w_save_pc   = 32'd0;

        if (rst) begin
            // Vector 0 with pc_write loads PC=0 at the reset edge.
            exception = 1'b1;
            pc_write  = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (vector_ex != 5'd0) begin
                        flush_if  = 1'b1;
                        flush_id  = 1'b1;
                        flush_ex  = 1'b1;
                        if (in_handler_q) begin
                            state_d = HALT;
                        end else begin
                            w_take      = 1'b1;
                            vector_no_3 = vector_ex;
                            w_save_pc   = pc_ex;
                        end
                    end else if ((vector_if != 5'd0) && !stall) begin
                        flush_if = 1'b1;
                        if (in_handler_q) begin
                            flush_id = 1'b1;
                            flush_ex = 1'b1;
                            state_d  = HALT;
                        end else begin
                            w_take      = 1'b1;
                            vector_no_3 = vector_if;
                            w_save_pc   = pc_if;
                        end
                    end else if (rfe_id && !stall && !su_q) begin
                        flush_if = 1'b1;
                        flush_id = 1'b1;
                        if (in_handler_q) begin
                            flush_ex = 1'b1;
                            state_d  = HALT;
                        end else begin
                            w_take      = 1'b1;
                            vector_no_3 = PRIV_VEC;
                            w_save_pc   = pc_ex;
                        end
                    end else if (rfe_id && !stall) begin
                        rfe      = 1'b1;
                        pc_write = 1'b1;
                        flush_if = 1'b1;
                        w_do_rfe = 1'b1;
                    end else if (irq && ie_q && !stall) begin
                        flush_if    = 1'b1;
                        w_take      = 1'b1;
                        vector_no_3 = IRQ_VEC;
                        w_save_pc   = pc_if;
                    end else begin
                        if (jr_id)             pc_src = 2'b11;
                        else if (branch_taken) pc_src = 2'b10;
                        else if (jump_id)      pc_src = 2'b01;
                        pc_write = !stall;
                        flush_if = (pc_src != 2'b00);
                    end

                    if (w_take) begin
                        exception = 1'b1;
                        pc_write  = 1'b1;
                        state_d   = DRAIN;
                    end
                end
                DRAIN: begin
                    // Vector fetch in flight: all events are masked for this cycle.
                    pc_write = !stall;
                    state_d  = RUN;
                end
                default: begin
                    flush_if = 1'b1;
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                    halted   = 1'b1;
                    state_d  = HALT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            su_q         <= 1'b1;
            ie_q         <= 1'b0;
            in_handler_q <= 1'b0;
            sv_su_q      <= 1'b1;
            sv_ie_q      <= 1'b0;
            iar_q        <= 32'd0;
        end else begin
            state_q <= state_d;
            if (w_take) begin
                iar_q        <= w_save_pc;
                sv_su_q      <= su_q;
                sv_ie_q      <= ie_q;
                su_q         <= 1'b1;
                ie_q         <= 1'b0;
                in_handler_q <= 1'b1;
            end else if (w_do_rfe) begin
                su_q         <= sv_su_q;
                ie_q         <= sv_ie_q;
                in_handler_q <= 1'b0;
            end
        end
    end

    assign IAR_pc = iar_q;
    assign s_u    = su_q;

endmodule
`default_nettype wire
